// File: rtl/note_rom_arbiter_if.sv
// -----------------------------------------------------------------------------
// note_rom_arbiter_if
// Bundle of the request, ROM and read-data signals shared between the
// note-sequencer channels and note_rom_arbiter.
//
//   i_req        [NUM_CH]          per-channel level read request (bit c = ch c)
//   i_addr       [NUM_CH*ADDR_W]   per-channel read address, ch c at [c*ADDR_W +: ADDR_W]
//   o_grant      [NUM_CH]          one-hot registered grant pulse
//   o_rom_addr   [ADDR_W]          registered address to the shared synchronous ROM
//   i_rom_data   [DATA_W]          ROM read data, valid one cycle after o_rom_addr
//   o_data       [DATA_W]          registered read data shared by all channels
//   o_data_valid [NUM_CH]          one-hot; bit c marks o_data as belonging to ch c
//
// Modports: slave  = arbiter side, master = requesters plus ROM side.
// -----------------------------------------------------------------------------
interface note_rom_arbiter_if #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) ();

    logic [NUM_CH-1:0]        i_req;
    logic [NUM_CH*ADDR_W-1:0] i_addr;
    logic [NUM_CH-1:0]        o_grant;
    logic [ADDR_W-1:0]        o_rom_addr;
    logic [DATA_W-1:0]        i_rom_data;
    logic [DATA_W-1:0]        o_data;
    logic [NUM_CH-1:0]        o_data_valid;

    modport slave (
        input  i_req,
        input  i_addr,
        input  i_rom_data,
        output o_grant,
        output o_rom_addr,
        output o_data,
        output o_data_valid
    );

    modport master (
        output i_req,
        output i_addr,
        output i_rom_data,
        input  o_grant,
        input  o_rom_addr,
        input  o_data,
        input  o_data_valid
    );

endinterface

// File: rtl/note_rom_arbiter.sv
// -----------------------------------------------------------------------------
// note_rom_arbiter
// Time-shares one 1-cycle-latency synchronous ROM among NUM_CH note-sequencer
// channels. One read is issued per cycle at most; channels are served
// round-robin and a channel with a read still in flight is skipped.
//
// Pipeline (edge k = grant edge):
//   edge k   : o_grant / o_rom_addr registered for the winning channel
//   edge k+1 : ROM registers its data (external)
//   edge k+2 : o_data <= i_rom_data, o_data_valid <= grant delayed by two
//
// Ports:
//   i_clk  clock, all state updates on the rising edge
//   i_rst  synchronous active-high reset
//   bus    note_rom_arbiter_if.slave (requests, ROM address/data, read data)
// -----------------------------------------------------------------------------
module note_rom_arbiter #(
    parameter int NUM_CH = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    note_rom_arbiter_if.slave        bus
);

    localparam int IDX_W = $clog2(NUM_CH);
    // One extra bit so ptr + offset cannot wrap before the modulo correction.
    localparam int SUM_W = IDX_W + 1;

    logic [IDX_W-1:0]  ptr;
    logic [NUM_CH-1:0] grant_d1;
    logic [NUM_CH-1:0] in_flight;
    logic [NUM_CH-1:0] eligible;

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic [ADDR_W-1:0] win_addr;
    logic [NUM_CH-1:0] grant_next;
    logic [IDX_W-1:0]  ptr_next;
    logic [SUM_W-1:0]  cand_sum;
    logic [IDX_W-1:0]  cand;
    logic [DATA_W-1:0] rom_word;

    assign rom_word = bus.i_rom_data;

    // A read is in flight from the grant edge until the edge that raises its
    // o_data_valid; those two cycles are exactly where the grant sits in
    // o_grant or grant_d1, so no separate flag register is needed. The
    // channel becomes eligible again in the cycle its data_valid is high.
    assign in_flight = bus.o_grant | grant_d1;
    assign eligible  = bus.i_req & ~in_flight;

    // Round-robin search starting at ptr, ascending modulo NUM_CH.
    // NOTE: every variable written in this block gets a default first so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand      = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cand_sum = {1'b0, ptr} + SUM_W'(i);
            if (cand_sum >= SUM_W'(NUM_CH)) begin
                cand_sum = cand_sum - SUM_W'(NUM_CH);
            end
            cand = cand_sum[IDX_W-1:0];
            if (!win_valid && eligible[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Winner decode: one-hot grant and address mux.
    always_comb begin
        grant_next = '0;
        win_addr   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (win_valid && (win_idx == IDX_W'(c))) begin
                grant_next[c] = 1'b1;
                win_addr      = bus.i_addr[c*ADDR_W +: ADDR_W];
            end
        end
    end

    assign ptr_next = (win_idx == IDX_W'(NUM_CH - 1)) ? '0 : win_idx + IDX_W'(1);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // Clearing grant and grant_d1 also drops every in-flight read, so
            // nothing granted before reset ever reaches o_data_valid.
            ptr              <= '0;
            grant_d1         <= '0;
            bus.o_grant      <= '0;
            bus.o_rom_addr   <= '0;
            bus.o_data       <= '0;
            bus.o_data_valid <= '0;
        end else begin
            bus.o_grant      <= grant_next;
            grant_d1         <= bus.o_grant;
            bus.o_data_valid <= grant_d1;
            // Address and pointer only move on a grant; idle cycles hold them.
            if (win_valid) begin
                bus.o_rom_addr <= win_addr;
                ptr            <= ptr_next;
            end
            // o_data keeps its last value unless a read is landing.
            if (|grant_d1) begin
                bus.o_data <= rom_word;
            end
        end
    end

    a_grant_onehot: assert property (@(posedge i_clk) $onehot0(bus.o_grant));
    a_valid_onehot: assert property (@(posedge i_clk) $onehot0(bus.o_data_valid));
    a_no_double:    assert property (@(posedge i_clk) disable iff (i_rst)
                                     (grant_next & in_flight) == '0);

endmodule

// File: tb/tb_note_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_note_rom_arbiter
// Self-checking bench for note_rom_arbiter. A queue-based reference model
// (pending reads with due edges) is compared against the DUT every cycle;
// directed sequences pin the model with hand-computed literal expectations,
// then a randomized requester phase exercises the arbiter at length.
// -----------------------------------------------------------------------------
module tb_note_rom_arbiter;

    localparam int NUM_CH = 3;
    localparam int ADDR_W = 5;
    localparam int DATA_W = 16;

    logic i_clk = 1'b0;
    logic i_rst = 1'b1;

    note_rom_arbiter_if #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    note_rom_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus)
    );

    always #5 i_clk = ~i_clk;

    // Shared synchronous ROM with one cycle of latency.
    logic [DATA_W-1:0] rom [2**ADDR_W];
    always @(posedge i_clk) bus.i_rom_data <= rom[bus.o_rom_addr];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------- stimulus
    logic              req_v  [NUM_CH];
    logic [ADDR_W-1:0] addr_v [NUM_CH];

    task automatic drive();
        logic [NUM_CH-1:0]        r;
        logic [NUM_CH*ADDR_W-1:0] a;
        r = '0;
        a = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            r[c] = req_v[c];
            a[c*ADDR_W +: ADDR_W] = addr_v[c];
        end
        bus.i_req  = r;
        bus.i_addr = a;
    endtask

    task automatic set_req(input logic [NUM_CH-1:0] r);
        for (int c = 0; c < NUM_CH; c++) req_v[c] = r[c];
        drive();
    endtask

    task automatic step();
        @(negedge i_clk);
    endtask

    // ------------------------------------------------------- reference model
    // Each grant becomes a pending read due two edges later. A channel is busy
    // while it has a pending read whose due edge has not yet passed.
    typedef struct {
        int     ch;
        int     addr;
        longint due;
    } rd_t;

    rd_t               pend [$];
    longint            edge_cnt   = 0;
    bit                model_live = 1'b0;
    int                m_ptr      = 0;
    int                m_win;
    logic [NUM_CH-1:0] m_busy;
    logic [NUM_CH-1:0] m_grant    = '0;
    logic [NUM_CH-1:0] m_valid    = '0;
    logic [ADDR_W-1:0] m_rom_addr = '0;
    logic [DATA_W-1:0] m_data     = '0;

    always @(posedge i_clk) begin
        edge_cnt++;
        if (i_rst) begin
            pend.delete();
            m_ptr      = 0;
            m_grant    = '0;
            m_valid    = '0;
            m_rom_addr = '0;
            m_data     = '0;
            model_live = 1'b1;
        end else begin
            m_busy = '0;
            foreach (pend[i]) m_busy[pend[i].ch] = 1'b1;
            m_win = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                if (m_win < 0 && bus.i_req[(m_ptr + i) % NUM_CH] && !m_busy[(m_ptr + i) % NUM_CH])
                    m_win = (m_ptr + i) % NUM_CH;
            end
            m_valid = '0;
            if (pend.size() > 0 && pend[0].due == edge_cnt) begin
                m_valid[pend[0].ch] = 1'b1;
                m_data = rom[pend[0].addr];
                void'(pend.pop_front());
            end
            m_grant = '0;
            if (m_win >= 0) begin
                m_grant[m_win] = 1'b1;
                m_rom_addr = bus.i_addr[m_win*ADDR_W +: ADDR_W];
                m_ptr = (m_win + 1) % NUM_CH;
                pend.push_back('{m_win, int'(m_rom_addr), edge_cnt + 2});
            end
        end
    end

    // Single compare process: every cycle once the model has seen reset.
    always @(negedge i_clk) begin
        if (model_live) begin
            check("model_grant",      bus.o_grant,      m_grant);
            check("model_rom_addr",   bus.o_rom_addr,   m_rom_addr);
            check("model_data_valid", bus.o_data_valid, m_valid);
            check("model_data",       bus.o_data,       m_data);
        end
    end

    // --------------------------------------------------------------- helpers
    task automatic do_reset();
        i_rst = 1'b1;
        set_req('0);
        step();
        step();
        check("rst_grant",      bus.o_grant,      0);
        check("rst_data_valid", bus.o_data_valid, 0);
        check("rst_rom_addr",   bus.o_rom_addr,   0);
        check("rst_data",       bus.o_data,       0);
        i_rst = 1'b0;
    endtask

    task automatic drain();
        set_req('0);
        repeat (3) step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
        $fatal(1);
    end

    logic [DATA_W-1:0] lit_data [NUM_CH];
    int  k_hit;
    int  n0;
    bit  got;
    logic [ADDR_W-1:0] held_addr;

    initial begin
        for (int i = 0; i < 2**ADDR_W; i++) rom[i] = DATA_W'($urandom);
        rom[5] = 16'h1234;
        rom[1] = 16'h0A01;
        rom[2] = 16'h0B02;
        rom[3] = 16'h0C03;
        lit_data[0] = 16'h0A01;
        lit_data[1] = 16'h0B02;
        lit_data[2] = 16'h0C03;
        for (int c = 0; c < NUM_CH; c++) begin
            req_v[c]  = 1'b0;
            addr_v[c] = '0;
        end
        drive();
        step();

        // Single request: grant after edge 1, data after edge 3.
        do_reset();
        addr_v[0] = 5'd5;
        set_req(3'b001);
        step();
        check("single_grant",    bus.o_grant,    3'b001);
        check("single_rom_addr", bus.o_rom_addr, 5);
        set_req('0);
        step();
        step();
        check("single_data",  bus.o_data,       16'h1234);
        check("single_valid", bus.o_data_valid, 3'b001);
        step();
        check("single_valid_drop", bus.o_data_valid, 0);
        check("single_data_hold",  bus.o_data,       16'h1234);
        drain();

        // Simultaneous requests held: grants rotate 0,1,2,0,...
        do_reset();
        for (int c = 0; c < NUM_CH; c++) addr_v[c] = ADDR_W'(c + 1);
        set_req(3'b111);
        for (int j = 1; j <= 8; j++) begin
            step();
            check("rr_grant", bus.o_grant, 3'b001 << ((j - 1) % NUM_CH));
            if (j >= 3) begin
                check("rr_valid", bus.o_data_valid, 3'b001 << ((j - 3) % NUM_CH));
                check("rr_data",  bus.o_data,       lit_data[(j - 3) % NUM_CH]);
            end
        end
        drain();

        // Fairness: ch0 continuous, ch2 once.
        do_reset();
        addr_v[0] = 5'd4;
        addr_v[2] = 5'd6;
        set_req(3'b101);
        got   = 1'b0;
        k_hit = 0;
        for (int k = 1; k <= NUM_CH + 2; k++) begin
            if (!got) begin
                step();
                if (bus.o_grant[2]) begin
                    got   = 1'b1;
                    k_hit = k;
                    req_v[2] = 1'b0;
                    drive();
                end
            end
        end
        check("fair_ch2_within_n", (got && k_hit <= NUM_CH), 1);
        check("fair_ch2_cycle",    k_hit, 2);
        n0 = 0;
        for (int k = 0; k < 9; k++) begin
            step();
            if (bus.o_grant[0]) n0++;
        end
        check("fair_ch0_grant_count", n0, 3);
        drain();

        // Idle: outputs quiet, address and pointer held.
        do_reset();
        addr_v[1] = 5'd7;
        set_req(3'b010);
        step();
        check("idle_pre_grant", bus.o_grant, 3'b010);
        set_req('0);
        step();
        step();
        check("idle_pre_valid", bus.o_data_valid, 3'b010);
        held_addr = bus.o_rom_addr;
        check("idle_held_addr", held_addr, 7);
        for (int k = 0; k < 10; k++) begin
            step();
            check("idle_grant",    bus.o_grant,      0);
            check("idle_valid",    bus.o_data_valid, 0);
            check("idle_rom_addr", bus.o_rom_addr,   7);
        end
        for (int c = 0; c < NUM_CH; c++) addr_v[c] = ADDR_W'(c + 1);
        set_req(3'b111);
        step();
        check("idle_ptr_kept", bus.o_grant, 3'b100);
        drain();

        // Reset one cycle after a grant to channel 1.
        do_reset();
        addr_v[1] = 5'd9;
        set_req(3'b010);
        step();
        check("midrst_grant", bus.o_grant, 3'b010);
        i_rst = 1'b1;
        set_req('0);
        step();
        check("midrst_valid_in_rst", bus.o_data_valid, 0);
        check("midrst_grant_in_rst", bus.o_grant,      0);
        i_rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("midrst_valid_after", bus.o_data_valid, 0);
        end
        addr_v[0] = 5'd2;
        set_req(3'b011);
        step();
        check("midrst_search_from_0", bus.o_grant, 3'b001);
        drain();

        // Abandoned request on channel 1.
        do_reset();
        addr_v[0] = 5'd4;
        addr_v[1] = 5'd8;
        set_req(3'b011);
        step();
        check("abandon_ch0_wins", bus.o_grant, 3'b001);
        set_req('0);
        for (int k = 0; k < 5; k++) begin
            step();
            check("abandon_no_grant1", bus.o_grant[1],      0);
            check("abandon_no_valid1", bus.o_data_valid[1], 0);
        end

        // Randomized requesters, with occasional resets.
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (i_rst) i_rst = 1'b0;
            else if ($urandom_range(0, 299) == 0) i_rst = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                if (req_v[c]) begin
                    if (bus.o_grant[c]) req_v[c] = ($urandom_range(0, 3) == 0);
                    else if ($urandom_range(0, 9) == 0) req_v[c] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_v[c]  = 1'b1;
                    addr_v[c] = ADDR_W'($urandom);
                end
            end
            drive();
            step();
        end
        i_rst = 1'b0;
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
